// File: rtl/gs_regfile_mp.sv
// Multi-ported register file with a power-up zeroing sweep, write-to-read forwarding
// and a per-register pending scoreboard. Register 0 is hardwired to zero.
module gs_regfile_mp #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pend,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t            state;
  logic [AW-1:0]     init_cnt;
  logic [XLEN-1:0]   rf [NREGS];
  logic [NREGS-1:0]  pend;

  // Sweep controller: one register cleared per cycle, then hand over to RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      init_cnt <= '0;
      ready    <= 1'b0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + AW'(1);
      if (init_cnt == AW'(NREGS - 1)) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end
  end

  // Storage array has no reset; the sweep is the only clearing mechanism
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      rf[init_cnt] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(0)))
          rf[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  // Scoreboard: writes clear, alloc applied last so it wins a same-register collision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= '0;
    end else if (state == RUN) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(0)))
          pend[wr_addr[j*AW +: AW]] <= 1'b0;
      end
      if (alloc_en && (alloc_addr != AW'(0)))
        pend[alloc_addr] <= 1'b1;
    end
  end

  // Combinational read ports; ascending write scan lets the highest port win the bypass
  always_comb begin
    logic [AW-1:0] ra;
    ra      = '0;
    rd_data = '0;
    rd_pend = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = rd_addr[i*AW +: AW];
      if ((state == RUN) && (ra != AW'(0))) begin
        rd_data[i*XLEN +: XLEN] = rf[ra];
        rd_pend[i]              = pend[ra];
        if (BYPASS != 0) begin
          for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) begin
              rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
              rd_pend[i]              = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/gs_regfile_mp.md
GS_REGFILE_MP -- requirements
Module: gs_regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: register data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, power of two ≥4: number of architectural registers; AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2: number of read ports.
REQ-004 SHALL have parameter NWR, default 2: number of write ports.
REQ-005 SHALL have parameter BYPASS, default 1: 1 enables same-cycle write-to-read forwarding, 0 disables it.
REQ-006 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port ready, output, 1: high when the array is initialised and accepting traffic.
REQ-009 SHALL have port rd_addr, input, NRD*AW: packed read addresses, with port i at bits [i*AW +: AW].
REQ-010 SHALL have port rd_data, output, NRD*XLEN: packed read data.
REQ-011 SHALL have port rd_pend, output, NRD: high when the addressed register has an outstanding producer.
REQ-012 SHALL have port wr_en, input, NWR: per-port write enables.
REQ-013 SHALL have port wr_addr, input, NWR*AW: packed write addresses.
REQ-014 SHALL have port wr_data, input, NWR*XLEN: packed write data.
REQ-015 SHALL have port alloc_en, input, 1: marks a register as awaiting a result.
REQ-016 SHALL have port alloc_addr, input, AW: the register to mark pending.

Function
REQ-017 SHALL implement a two-state FSM with states INIT and RUN, and ready = (state == RUN).
REQ-018 SHALL, in INIT, write zero to rf[init_cnt] each cycle and then increment init_cnt; on the cycle it writes NREGS-1, the FSM moves to RUN, so ready rises exactly NREGS cycles after rst deasserts.
REQ-019 SHALL, while in INIT, ignore wr_en and alloc_en, and drive rd_data = 0 and rd_pend = 0 on all ports.
REQ-020 SHALL keep the register array itself free of reset; clearing the array is done only by the INIT sweep.
REQ-021 SHALL hardwire register 0: reads return 0, rd_pend = 0, and writes and allocs to register 0 are dropped.
REQ-022 SHALL, in RUN, on each rising edge, update rf[wr_addr[j]] <= wr_data[j] for every j with wr_en[j] = 1 and a nonzero address.
REQ-023 SHALL resolve multiple enabled writes to the same address in one cycle in favour of the highest port index j.
REQ-024 SHALL make reads combinational: rd_data[i] = rf[rd_addr[i]], with zero-cycle latency.
REQ-025 SHALL, when BYPASS = 1 and rd_addr[i] is nonzero and matches an enabled write, return that write's wr_data, choosing the highest matching j; with BYPASS = 0, rd_data SHALL show the old value until the next cycle.
REQ-026 SHALL keep one pending bit per register, cleared by an enabled write to that register and set by alloc_en to alloc_addr.
REQ-027 SHALL, when alloc and write target the same register in the same cycle, leave the pending bit set (alloc wins).
REQ-028 SHALL, when BYPASS = 1 and a write to the addressed register is enabled in the current cycle, drive rd_pend[i] = 0; otherwise rd_pend[i] SHALL equal the registered pending bit.
REQ-029 SHALL have no back-pressure: writes and allocs in RUN are always accepted in the cycle presented.

Reset
REQ-030 SHALL, when rst is low, immediately force state = INIT, init_cnt = 0, all pending bits = 0 and ready = 0, regardless of clk.
REQ-031 SHALL abandon an in-flight INIT sweep or RUN traffic on reset assertion and restart the sweep from register 0 once rst returns high.
REQ-032 SHALL let array contents be undefined between reset assertion and completion of the INIT sweep; they are never visible, per REQ-019.

Verification (defaults: XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, BYPASS = 1)
REQ-033 SHALL cover init timing: release rst and count cycles -> ready = 0 for 32 cycles and 1 on cycle 33; all registers then read 0 with rd_pend = 0.
REQ-034 SHALL cover the write collision: wr_en = 2'b11, both ports to address 5, data 0xAAAA_0000 on port 0 and 0x5555_1111 on port 1 -> the same-cycle read of 5 returns 0x5555_1111, and so does the next-cycle read.
REQ-035 SHALL cover the zero register: write 0xDEAD_BEEF to address 0 and alloc address 0 -> reads of 0 return 0 with rd_pend = 0.
REQ-036 SHALL cover the scoreboard: alloc 7 -> rd_pend(7) = 1 next cycle; a write to 7 clears it; simultaneous alloc and write to 7 -> rd_pend(7) = 1 the following cycle.
REQ-037 SHALL cover the no-bypass build: with BYPASS = 0, write 0x1234 to address 3 while reading 3 -> the old value this cycle and 0x1234 the next cycle.
REQ-038 SHALL cover reset mid-sweep: assert rst at sweep cycle 10 and release -> ready rises 32 cycles after release, and writes issued before ready have no effect.
